// File: rtl/lsu_mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lsu_mem_stage
// Brief    : RISC-V load/store memory stage. Issues one aligned data-memory
//            request per load/store, freezes the pipeline while the access is
//            outstanding, and returns the sign/zero-extended load result.
//            Optional request/response watchdog: define LSU_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] w_data_i,
    output logic [31:0] rd_data_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        misalign_o,
    output logic        err_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rd_data_q;
    logic        misalign_q;

    logic        access_req;
    logic        is_store;
    logic        illegal;
    logic        misaligned;
    logic        accept;
    logic        reject;
    logic        timeout;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    // ------------------------------------------------------------------
    // Request decode: a simultaneous read and write is handled as a store
    // ------------------------------------------------------------------
    assign access_req = mem_read_i | mem_write_i;
    assign is_store   = mem_write_i;

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (is_store) begin
            illegal = funct3_i[2];
        end else begin
            illegal = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
        end
        if (funct3_i[1:0] == 2'b01) begin
            misaligned = addr_i[0];
        end else if (funct3_i[1:0] == 2'b10) begin
            misaligned = (addr_i[1:0] != 2'b00);
        end
    end

    assign accept = (state == IDLE) && access_req && !illegal && !misaligned;
    assign reject = (state == IDLE) && access_req && (illegal || misaligned);

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = 32'h0000_0000;
        case (funct3_i[1:0])
            2'b00:   be_new = 4'b0001 << addr_i[1:0];
            2'b01:   be_new = addr_i[1] ? 4'b1100 : 4'b0011;
            default: be_new = 4'b1111;
        endcase
        if (is_store) begin
            case (funct3_i[1:0])
                2'b00:   wdata_new = {4{w_data_i[7:0]}};
                2'b01:   wdata_new = {2{w_data_i[15:0]}};
                default: wdata_new = w_data_i;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load lane extraction and extension
    // ------------------------------------------------------------------
    always_comb begin
        load_byte = 8'h00;
        load_half = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        load_data = dmem_rdata_i;
        case (addr_q[1:0])
            2'b00:   load_byte = dmem_rdata_i[7:0];
            2'b01:   load_byte = dmem_rdata_i[15:8];
            2'b10:   load_byte = dmem_rdata_i[23:16];
            default: load_byte = dmem_rdata_i[31:24];
        endcase
        case (funct3_q)
            F3_B:    load_data = {{24{load_byte[7]}}, load_byte};
            F3_H:    load_data = {{16{load_half[15]}}, load_half};
            F3_BU:   load_data = {24'h00_0000, load_byte};
            F3_HU:   load_data = {16'h0000, load_half};
            F3_W:    load_data = dmem_rdata_i;
            default: load_data = dmem_rdata_i;
        endcase
    end

    // ------------------------------------------------------------------
    // Optional watchdog over the REQ + WAIT interval
    // ------------------------------------------------------------------
`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if ((state == REQ) || (state == WAIT)) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    assign timeout = ((state == REQ) || (state == WAIT)) &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    logic [31:0] tmo_cfg_unused;

    assign tmo_cfg_unused = 32'(TIMEOUT_CYCLES);
    assign timeout        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (timeout) begin
                    state_nxt = DONE;
                end else if (dmem_gnt_i) begin
                    state_nxt = we_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (timeout || dmem_rvalid_i) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request fields are frozen from capture until the grant cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= 32'h0000_0000;
            funct3_q   <= 3'b000;
            we_q       <= 1'b0;
            be_q       <= 4'b0000;
            wdata_q    <= 32'h0000_0000;
            rd_data_q  <= 32'h0000_0000;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= reject;
            if (accept) begin
                addr_q   <= addr_i;
                funct3_q <= funct3_i;
                we_q     <= is_store;
                be_q     <= be_new;
                wdata_q  <= wdata_new;
            end
            if ((state == WAIT) && dmem_rvalid_i && !timeout) begin
                rd_data_q <= load_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs; the IDLE stall term is combinational so the pipeline freezes
    // in the issue cycle, and is masked while reset is held
    // ------------------------------------------------------------------
    assign stall_o      = rst && (accept || (state == REQ) || (state == WAIT));
    assign done_o       = (state == DONE);
    assign misalign_o   = misalign_q;
    assign err_o        = timeout;
    assign rd_data_o    = rd_data_q;
    assign dmem_req_o   = (state == REQ) && !timeout;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = {addr_q[31:2], 2'b00};
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_stage
// Brief    : Scoreboard bench for lsu_mem_stage with directed load/store vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_stage;

    localparam int K_HS   = 0;
    localparam int K_DONE = 1;
    localparam int K_MIS  = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        int          kind;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] w_data_i;
    logic [31:0] rd_data_o;
    logic        stall_o;
    logic        done_o;
    logic        misalign_o;
    logic        err_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    int   checks;
    int   failures;
    int   cyc;
    exp_t exp_q[$];
    exp_t mon_e;

    lsu_mem_stage #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .w_data_i     (w_data_i),
        .rd_data_o    (rd_data_o),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .misalign_o   (misalign_o),
        .err_o        (err_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_gnt_i   (dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i (dmem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic we, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd, input logic [31:0] rd);
        exp_t e;
        e.kind = kind; e.we = we; e.addr = a; e.be = be; e.wdata = wd; e.rd = rd;
        exp_q.push_back(e);
    endtask

    // Monitor: every observable DUT event must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (dmem_req_o && dmem_gnt_i) begin
                if (exp_q.size() != 0 && exp_q[0].kind == K_HS) begin
                    mon_e = exp_q.pop_front();
                    check(dmem_we_o == mon_e.we, "hs_we", {31'b0, dmem_we_o}, {31'b0, mon_e.we});
                    check(dmem_addr_o == mon_e.addr, "hs_addr", dmem_addr_o, mon_e.addr);
                    check(dmem_be_o == mon_e.be, "hs_be", {28'b0, dmem_be_o}, {28'b0, mon_e.be});
                    check(dmem_wdata_o == mon_e.wdata, "hs_wdata", dmem_wdata_o, mon_e.wdata);
                end else begin
                    check(1'b0, "hs_unexpected", dmem_addr_o, 32'h0);
                end
            end
            if (done_o) begin
                if (exp_q.size() != 0 && exp_q[0].kind == K_DONE) begin
                    mon_e = exp_q.pop_front();
                    check(rd_data_o == mon_e.rd, "done_rd_data", rd_data_o, mon_e.rd);
                    check(!stall_o, "done_stall", {31'b0, stall_o}, 32'h0);
                end else begin
                    check(1'b0, "done_unexpected", {31'b0, done_o}, 32'h0);
                end
            end
            if (misalign_o) begin
                if (exp_q.size() != 0 && exp_q[0].kind == K_MIS) begin
                    mon_e = exp_q.pop_front();
                    check(!dmem_req_o && !stall_o, "mis_req_stall",
                          {30'b0, dmem_req_o, stall_o}, 32'h0);
                end else begin
                    check(1'b0, "mis_unexpected", {31'b0, misalign_o}, 32'h0);
                end
            end
            if (err_o) begin
                if (exp_q.size() != 0 && exp_q[0].kind == K_ERR) begin
                    mon_e = exp_q.pop_front();
                    check(!dmem_req_o, "err_req", {31'b0, dmem_req_o}, 32'h0);
                end else begin
                    check(1'b0, "err_unexpected", {31'b0, err_o}, 32'h0);
                end
            end
        end
    end

    // One access: ok=1 expects a handshake and completion, ok=0 a misalign pulse
    task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                       input int gdly, input int rvdly, input logic ok,
                       input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd);
        int start;
        int lat;
        if (ok) begin
            push(K_HS, wr, {a[31:2], 2'b00}, ebe, ewd, 32'h0);
            push(K_DONE, 1'b0, 32'h0, 4'h0, 32'h0, erd);
        end else begin
            push(K_MIS, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        end
        mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = a; w_data_i = wd;
        start = cyc;
        #1;
        check(stall_o == ok, "issue_stall", {31'b0, stall_o}, {31'b0, ok});
        @(posedge clk); #1;
        mem_read_i = 1'b0; mem_write_i = 1'b0;
        if (ok) begin
            for (int i = 0; i < gdly; i++) begin
                check(stall_o && dmem_req_o, "req_hold", {30'b0, stall_o, dmem_req_o}, 32'h3);
                @(posedge clk); #1;
            end
            dmem_gnt_i = 1'b1;
            @(posedge clk); #1;
            dmem_gnt_i = 1'b0;
            if (!wr) begin
                for (int i = 0; i < rvdly; i++) begin
                    check(stall_o && !dmem_req_o, "wait_hold", {30'b0, stall_o, dmem_req_o}, 32'h2);
                    @(posedge clk); #1;
                end
                dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
                @(posedge clk); #1;
                dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
            end
            for (int k = 0; k < 4 && !done_o; k++) begin
                @(posedge clk); #1;
            end
            lat = wr ? (2 + gdly) : (3 + gdly + rvdly);
            check(done_o == 1'b1, "done_seen", {31'b0, done_o}, 32'h1);
            check(cyc - start == lat, "latency", 32'(cyc - start), 32'(lat));
            @(posedge clk); #1;
        end else begin
            check(!dmem_req_o && !stall_o, "rej_no_req", {30'b0, dmem_req_o, stall_o}, 32'h0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        checks = 0; failures = 0; cyc = 0;
        rst = 1'b0;
        mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b000;
        addr_i = 32'h0; w_data_i = 32'h0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        #3;
        check(rd_data_o == 32'h0, "rst_rd_data", rd_data_o, 32'h0);
        check({stall_o, done_o, misalign_o, err_o, dmem_req_o, dmem_we_o} == 6'b0,
              "rst_ctrl", {26'b0, stall_o, done_o, misalign_o, err_o, dmem_req_o, dmem_we_o}, 32'h0);
        check(dmem_addr_o == 32'h0 && dmem_be_o == 4'h0 && dmem_wdata_o == 32'h0,
              "rst_bus", dmem_addr_o | dmem_wdata_o | {28'b0, dmem_be_o}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        run(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 1, 4'b1000, 32'h0, 32'hFFFFFF80);
        run(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 1, 4'b1000, 32'h0, 32'h00000080);
        run(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0, 0, 1, 4'b1100, 32'hABCDABCD, 32'h00000080);
        run(1, 0, 3'b010, 32'h005, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        run(0, 1, 3'b010, 32'h040, 32'hDEADBEEF, 32'h0, 3, 0, 1, 4'b1111, 32'hDEADBEEF, 32'h00000080);
        run(1, 0, 3'b001, 32'h0A2, 32'h0, 32'h80017FFF, 1, 2, 1, 4'b1100, 32'h0, 32'hFFFF8001);
        run(1, 0, 3'b101, 32'h0A0, 32'h0, 32'h1234F00D, 0, 1, 1, 4'b0011, 32'h0, 32'h0000F00D);
        run(1, 0, 3'b010, 32'h0A4, 32'h0, 32'hCAFEF00D, 2, 0, 1, 4'b1111, 32'h0, 32'hCAFEF00D);
        run(1, 0, 3'b000, 32'h001, 32'h0, 32'h00007F00, 0, 0, 1, 4'b0010, 32'h0, 32'h0000007F);
        run(0, 1, 3'b000, 32'h013, 32'h000000A5, 32'h0, 0, 0, 1, 4'b1000, 32'hA5A5A5A5, 32'h0000007F);
        run(1, 1, 3'b010, 32'h020, 32'h11223344, 32'h0, 0, 1, 1, 4'b1111, 32'h11223344, 32'h0000007F);
        run(1, 0, 3'b011, 32'h000, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        run(0, 1, 3'b100, 32'h008, 32'hFF, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        run(1, 0, 3'b110, 32'h000, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        run(0, 1, 3'b001, 32'h201, 32'h1234, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        run(1, 0, 3'b101, 32'h003, 32'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0, 32'h0);

        // Bus responses while idle must not start or complete anything
        dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
        @(posedge clk); #1;
        check(!done_o && !stall_o && !dmem_req_o, "idle_ignore",
              {29'b0, done_o, stall_o, dmem_req_o}, 32'h0);
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        @(posedge clk); #1;
        check(rd_data_o == 32'h0000007F, "idle_rd_hold", rd_data_o, 32'h0000007F);

`ifdef LSU_TIMEOUT_EN
        push(K_ERR, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        push(K_DONE, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0000007F);
        mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h50;
        @(posedge clk); #1;
        mem_read_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check(!err_o && stall_o, "tmo_pending", {30'b0, err_o, stall_o}, 32'h1);
            @(posedge clk); #1;
        end
        check(err_o == 1'b1, "tmo_err", {31'b0, err_o}, 32'h1);
        @(posedge clk); #1;
        check(done_o && !stall_o && !err_o, "tmo_done", {29'b0, done_o, stall_o, err_o}, 32'h4);
        @(posedge clk); #1;
`endif

        // Reset asserted while a load waits for its data
        push(K_HS, 1'b0, 32'h30, 4'b1111, 32'h0, 32'h0);
        mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h30;
        @(posedge clk); #1;
        mem_read_i = 1'b0;
        dmem_gnt_i = 1'b1;
        @(posedge clk); #1;
        dmem_gnt_i = 1'b0;
        check(stall_o && !dmem_req_o, "in_wait", {30'b0, stall_o, dmem_req_o}, 32'h2);
        rst = 1'b0;
        #1;
        check(!dmem_req_o && !stall_o && !done_o, "rst_mid_ctrl",
              {29'b0, dmem_req_o, stall_o, done_o}, 32'h0);
        check(rd_data_o == 32'h0, "rst_mid_rd", rd_data_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        for (int k = 0; k < 3; k++) begin
            check(!done_o && !stall_o && rd_data_o == 32'h0, "late_rvalid",
                  rd_data_o | {30'b0, done_o, stall_o}, 32'h0);
            @(posedge clk); #1;
        end

        check(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum number of cycles spent in REQ plus WAIT before abort (used only with LSU_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mem_read_i  in  1  load request from the current instruction.
REQ-005 SHALL have port mem_write_i  in  1  store request from the current instruction.
REQ-006 SHALL have port funct3_i  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port addr_i  in  32  byte address.
REQ-008 SHALL have port w_data_i  in  32  raw rs2 store data.
REQ-009 SHALL have port rd_data_o  out  32  extended load result.
REQ-010 SHALL have ports stall_o, done_o, misalign_o, err_o  out  1 each: pipeline freeze; completion pulse; misalign/illegal pulse; timeout pulse.
REQ-011 SHALL have ports dmem_req_o 1, dmem_we_o 1, dmem_addr_o 32, dmem_be_o 4, dmem_wdata_o 32 (all out), and dmem_gnt_i 1, dmem_rvalid_i 1, dmem_rdata_i 32 (all in).

Function
REQ-012 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-013 IDLE: on mem_read_i or mem_write_i with a legal, aligned access, SHALL capture addr, funct3, data and direction, then go to REQ; stall_o SHALL be asserted combinationally in that same cycle.
REQ-014 Simultaneous mem_read_i and mem_write_i SHALL be treated as a store.
REQ-015 Alignment rules: H/HU with addr[0]=1 and W with addr[1:0]!=0 are misaligned; loads with funct3 011/110/111 and stores with funct3[2]=1 are illegal.
REQ-016 A misaligned or illegal access SHALL pulse misalign_o for 1 cycle, issue no dmem_req_o, keep stall_o=0, and remain in IDLE.
REQ-017 REQ: dmem_req_o=1 with stable dmem_we_o, dmem_addr_o, dmem_be_o and dmem_wdata_o until the cycle dmem_gnt_i=1; on grant a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-018 WAIT: on dmem_rvalid_i, SHALL register the extracted, extended data into rd_data_o and go to DONE.
REQ-019 DONE: done_o=1 and stall_o=0 for exactly 1 cycle, then go to IDLE.
REQ-020 stall_o SHALL be 1 throughout REQ and WAIT.
REQ-021 dmem_addr_o SHALL be {addr[31:2],2'b00}.
REQ-022 Byte enables: B/BU = 1<<addr[1:0]; H/HU = addr[1] ? 1100 : 0011; W = 1111.
REQ-023 Store data lane replication: SB = byte x4; SH = half x2; SW = unchanged.
REQ-024 Load extraction: select the byte or half by addr[1:0]; B/H sign-extend; BU/HU zero-extend.
REQ-025 rd_data_o SHALL hold its value until the next load completes.
REQ-026 dmem_gnt_i and dmem_rvalid_i received in IDLE or DONE SHALL be ignored.
REQ-027 A load where rvalid arrives in the cycle after gnt SHALL have minimum latency IDLE->DONE of 3 cycles.

Reset
REQ-028 rst=0 SHALL asynchronously force state IDLE, with rd_data_o=0 and all other outputs 0, including mid-transaction; the in-flight access SHALL be dropped.
REQ-029 Operation SHALL resume on the first rising edge of clk after rst=1.

Configuration
REQ-030 With LSU_TIMEOUT_EN defined, a counter SHALL count cycles in REQ and WAIT, reset on entry to REQ; when it reaches TIMEOUT_CYCLES, the block SHALL pulse err_o, leave rd_data_o unchanged, and go to DONE.
REQ-031 Without LSU_TIMEOUT_EN, no counter SHALL exist, err_o SHALL be tied to 0, and the FSM SHALL wait indefinitely.

Verification
REQ-032 LB addr 0x103, rdata 0x80FF1234 -> rd_data_o 0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-033 SH addr 0x202, w_data 0x0000ABCD -> dmem_addr_o 0x200, be 1100, wdata 0xABCDABCD, we=1.
REQ-034 LW addr 0x005 -> misalign_o pulses 1 cycle, dmem_req_o stays 0, stall_o stays 0.
REQ-035 Store with dmem_gnt_i delayed 3 cycles -> dmem_req_o and stall_o held 3 cycles, then done_o pulses once.
REQ-036 rst=0 while in WAIT -> immediate IDLE, dmem_req_o=0, rd_data_o=0; a late rvalid after release is ignored.
REQ-037 LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4 and gnt never asserted -> err_o pulses 4 cycles after REQ entry, done_o the next cycle, stall_o released.
